// File: rtl/rtlmem_rdstream.sv
`default_nettype none
// rtlmem_rdstream: streams a contiguous address range out of a fixed-latency memory
// through a credit-protected output FIFO as a valid/ready/last stream.  rev 1.0
module rtlmem_rdstream #(
  parameter int G_RDADDR  = 10,
  parameter int G_RDWIDTH = 16,
  parameter int G_LATENCY = 2,
  parameter int G_FDEPTH  = 4,
  parameter int G_FADDR   = 2
) (
  input  logic                 rclk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [G_RDADDR-1:0]  sbase,
  input  logic [G_RDADDR:0]    slen,
  output logic                 busy,
  output logic                 done,
  output logic                 memre,
  output logic [G_RDADDR-1:0]  memra,
  input  logic [G_RDWIDTH-1:0] memdo,
  output logic [G_RDWIDTH-1:0] odata,
  output logic                 ovalid,
  input  logic                 oready,
  output logic                 olast
);

  localparam int CW = G_FADDR + 2;
  localparam int LW = G_RDADDR + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(G_FDEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [G_RDADDR-1:0]  addr;
  logic [G_RDADDR-1:0]  last_ra;
  logic [LW-1:0]        remain;
  logic [G_LATENCY-1:0] vld_sr;
  logic [G_LATENCY-1:0] last_sr;
  logic [G_FADDR-1:0]   wptr;
  logic [G_FADDR-1:0]   rptr;
  logic [G_FADDR:0]     occ;
  logic [CW-1:0]        inflight;
  logic [G_RDWIDTH:0]   fifo_mem [G_FDEPTH];
  logic [G_RDWIDTH:0]   head;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 room;
  logic                 head_last;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < G_LATENCY; i++) begin
      inflight = inflight + CW'(vld_sr[i]);
    end
  end

  // Credit: every issued read owns a FIFO slot until it is popped.
  assign room      = (inflight + CW'(occ)) < DEPTH_C;
  assign push      = vld_sr[G_LATENCY-1];
  assign head      = fifo_mem[rptr];
  assign ovalid    = (occ != '0);
  assign pop       = ovalid && oready;
  assign head_last = head[G_RDWIDTH];
  assign odata     = ovalid ? head[G_RDWIDTH-1:0] : '0;
  assign olast     = ovalid && head_last;
  assign busy      = (state != IDLE);
  assign memre     = issue;
  assign memra     = issue ? addr : last_ra;

  always_ff @(posedge rclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE:  if (start && slen != '0) state_nx = RUN;
      RUN: begin
        if (room) begin
          issue = 1'b1;
          if (remain == LW'(1)) state_nx = DRAIN;
        end
      end
      DRAIN: if (pop && head_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      addr    <= '0;
      last_ra <= '0;
      remain  <= '0;
      vld_sr  <= '0;
      last_sr <= '0;
      wptr    <= '0;
      rptr    <= '0;
      occ     <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == IDLE && start && slen == '0) ||
              (state == DRAIN && pop && head_last);
      if (state == IDLE && start) begin
        addr   <= sbase;
        remain <= slen;
      end
      if (issue) begin
        addr    <= addr + G_RDADDR'(1);
        remain  <= remain - LW'(1);
        last_ra <= addr;
      end
      vld_sr[0]  <= issue;
      last_sr[0] <= issue && (remain == LW'(1));
      for (int i = 1; i < G_LATENCY; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
      if (push) wptr <= wptr + G_FADDR'(1);
      if (pop)  rptr <= rptr + G_FADDR'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (G_FADDR+1)'(1);
        2'b01:   occ <= occ - (G_FADDR+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: ovalid gates every read of it.
  always_ff @(posedge rclk) begin
    if (push) fifo_mem[wptr] <= {last_sr[G_LATENCY-1], memdo};
  end

endmodule
`default_nettype wire

// File: tb/tb_rtlmem_rdstream.sv
`default_nettype none
// tb_rtlmem_rdstream: directed + randomized checks of rtlmem_rdstream against
// a word-list reference model and a 2-cycle-latency memory model.
module tb_rtlmem_rdstream;

  logic        rclk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  sbase;
  logic [10:0] slen;
  logic        busy, done, memre, ovalid, oready, olast;
  logic [9:0]  memra;
  logic [15:0] memdo, odata;

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] mem_model [0:1023];
  logic [15:0] p1, p2;

  rtlmem_rdstream #(
    .G_RDADDR(10), .G_RDWIDTH(16), .G_LATENCY(2), .G_FDEPTH(4), .G_FADDR(2)
  ) dut (
    .rclk(rclk), .rst_n(rst_n), .start(start), .sbase(sbase), .slen(slen),
    .busy(busy), .done(done), .memre(memre), .memra(memra), .memdo(memdo),
    .odata(odata), .ovalid(ovalid), .oready(oready), .olast(olast)
  );

  always #5 rclk = ~rclk;

  // Memory: data for a read in cycle n is presented during cycle n+2.
  always @(posedge rclk) begin
    if (memre) p1 <= mem_model[memra];
    p2 <= p1;
  end
  assign memdo = p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_memre", memre, 0);
    check("rst_memra", memra, 0);
    check("rst_ovalid", ovalid, 0);
    check("rst_olast", olast, 0);
    check("rst_odata", odata, 0);
  endtask

  // mode: 0 oready=1, 1 stalled 20 cycles then random, 2 random oready
  // special: 0 none, 1 second start at cycle 3, 2 reset at cycle 5
  task automatic run_cmd(input logic [9:0] base, input logic [10:0] len,
                         input int mode, input int special);
    int c, issued, popped, done_cyc, budget, len_i, outst;
    logic [9:0]  exp_addr, a;
    logic [15:0] exp_q[$];
    logic        prev_stall;
    logic [15:0] prev_data;
    len_i = int'(len);
    exp_q = {};
    for (int i = 0; i < len_i; i++) begin
      a = base + 10'(i);
      exp_q.push_back(mem_model[a]);
    end
    @(posedge rclk); #1;
    start = 1'b1; sbase = base; slen = len; oready = (mode == 0);
    c = 0; issued = 0; popped = 0; done_cyc = -1; exp_addr = base;
    prev_stall = 1'b0; prev_data = '0;
    budget = len_i * 12 + 60;
    while (done_cyc < 0 && c < budget) begin
      @(posedge rclk); #1;
      c++;
      start = 1'b0;
      if (special == 1 && c == 3) begin
        start = 1'b1; sbase = base ^ 10'h155; slen = 11'd5;
      end
      if (special == 2 && c == 5) begin
        rst_n = 1'b0;
        break;
      end
      case (mode)
        0:       oready = 1'b1;
        1:       oready = (c > 20) ? 1'($urandom_range(0, 1)) : 1'b0;
        default: oready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (prev_stall) begin
        check("stall_valid", ovalid, 1);
        check("stall_data", odata, prev_data);
      end
      outst = issued - popped + (memre ? 1 : 0);
      check("credit_bound", outst <= 4, 1);
      if (mode == 0) begin
        check("rate_memre", memre, (c >= 1 && c <= len_i));
        check("rate_ovalid", ovalid, (c >= 4 && c <= len_i + 3));
      end
      if (memre) begin
        check("memra", memra, exp_addr);
        exp_addr = exp_addr + 10'd1;
        issued++;
      end
      if (ovalid && oready) begin
        check("no_extra_word", popped < len_i, 1);
        if (popped < len_i) begin
          check("odata", odata, exp_q[popped]);
          check("olast", olast, (popped == len_i - 1));
        end
        popped++;
      end
      if (done) begin
        done_cyc = c;
        check("busy_at_done", busy, 0);
      end else begin
        check("busy", busy, (len_i != 0));
      end
      if (mode == 1 && c == 20) check("issued_while_stalled", issued, 4);
      prev_stall = ovalid && !oready;
      prev_data  = odata;
    end
    if (special == 2) begin
      @(posedge rclk); #1;
      check_reset_outputs();
      rst_n = 1'b1;
    end else begin
      check("done_seen", done_cyc >= 0, 1);
      if (mode == 0) check("done_cycle", done_cyc, (len_i == 0) ? 1 : len_i + 4);
      check("words_popped", popped, len_i);
      check("reads_issued", issued, len_i);
      @(posedge rclk); #1;
      oready = 1'b1;
      #1;
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);
      check("idle_ovalid", ovalid, 0);
      check("idle_memre", memre, 0);
    end
  endtask

  initial begin
    logic [9:0]  rb;
    logic [10:0] rl;
    for (int i = 0; i < 1024; i++) mem_model[i] = 16'($urandom);
    rst_n = 1'b0; start = 1'b0; sbase = '0; slen = '0; oready = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    run_cmd(10'h010, 11'd8,    0, 0);
    run_cmd(10'h100, 11'd16,   1, 0);
    run_cmd(10'h3FE, 11'd4,    0, 0);
    run_cmd(10'h123, 11'd0,    0, 0);
    run_cmd(10'h200, 11'd1,    0, 0);
    run_cmd(10'h050, 11'd12,   0, 1);
    run_cmd(10'h080, 11'd8,    0, 2);
    run_cmd(10'h081, 11'd8,    0, 0);
    run_cmd(10'h2A5, 11'd1024, 0, 0);
    for (int k = 0; k < 6; k++) begin
      rb = 10'($urandom);
      rl = 11'($urandom_range(1, 40));
      run_cmd(rb, rl, 2, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
